// File: rtl/bram_burst_master.sv
// bram_burst_master: burst initiator for one port of a single-port BRAM with
// 1-cycle registered read latency. Read bursts stream out through a 2-entry
// buffer with valid/ready; write bursts are taken from a valid/ready stream.
module bram_burst_master #(
   parameter int DWIDTH = 8,
   parameter int WORDS  = 4096,
   parameter int ADDRS  = $clog2(WORDS),
   parameter int LWIDTH = ADDRS + 1
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic              i_cmd_write,
   input  logic [ADDRS-1:0]  i_cmd_addr,
   input  logic [LWIDTH-1:0] i_cmd_len,
   output logic              o_mem_we,
   output logic [ADDRS-1:0]  o_mem_addr,
   output logic [DWIDTH-1:0] o_mem_datai,
   input  logic [DWIDTH-1:0] i_mem_datao,
   output logic              o_rd_valid,
   input  logic              i_rd_ready,
   output logic [DWIDTH-1:0] o_rd_data,
   output logic              o_rd_last,
   input  logic              i_wr_valid,
   output logic              o_wr_ready,
   input  logic [DWIDTH-1:0] i_wr_data,
   output logic              o_done
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

   localparam logic [ADDRS-1:0] LAST_ADDR = ADDRS'(WORDS - 1);

   state_t                      r_state;
   logic [ADDRS-1:0]            r_addr;
   logic [LWIDTH-1:0]           r_rem;
   logic                        r_mem_we;
   logic [ADDRS-1:0]            r_mem_addr;
   logic [DWIDTH-1:0]           r_mem_datai;
   logic                        r_done;
   logic [1:0][DWIDTH-1:0]      r_fdata;
   logic [1:0]                  r_flast;
   logic [1:0]                  r_cnt;
   logic                        r_inf;
   logic                        r_inf_last;

   logic [ADDRS-1:0]            w_addr_nxt;
   logic                        w_pop;
   logic [2:0]                  w_occ;
   logic                        w_issue;
   logic                        w_wr_hs;
   logic                        w_rd_end;

   // Wrap explicitly so non-power-of-two depths work.
   assign w_addr_nxt = (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
   assign w_pop      = (r_cnt != 2'd0) && i_rd_ready;
   // Occupancy counts a same-cycle pop so full rate needs no bubble while the
   // buffer plus the in-flight word still never exceeds two entries.
   assign w_occ      = 3'(r_cnt) + 3'(r_inf) - 3'(w_pop);
   assign w_issue    = (r_state == S_READ) && (r_rem != '0) && (w_occ < 3'd2);
   assign w_wr_hs    = i_wr_valid && o_wr_ready;
   assign w_rd_end   = w_pop && r_flast[0];

   // During READ the live address counter drives the BRAM so that the word
   // issued this cycle is sampled at the coming edge.
   assign o_cmd_ready = (r_state == S_IDLE);
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = (r_state == S_READ) ? r_addr : r_mem_addr;
   assign o_mem_datai = r_mem_datai;
   assign o_rd_valid  = (r_cnt != 2'd0);
   assign o_rd_data   = r_fdata[0];
   assign o_rd_last   = r_flast[0] && (r_cnt != 2'd0);
   assign o_wr_ready  = (r_state == S_WRITE) && (r_rem != '0);
   assign o_done      = r_done;

   // Control FSM with address/length counters and the write port registers.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_rem       <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_datai <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_mem_we <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_cmd_valid) begin
                  r_addr <= i_cmd_addr;
                  r_rem  <= i_cmd_len;
                  if (i_cmd_len == '0) r_done <= 1'b1;
                  else                 r_state <= i_cmd_write ? S_WRITE : S_READ;
               end
            end
            S_READ: begin
               if (w_issue) begin
                  r_addr <= w_addr_nxt;
                  r_rem  <= r_rem - 1'b1;
               end
               if (w_rd_end) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end
            end
            S_WRITE: begin
               if (w_wr_hs) begin
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= r_addr;
                  r_mem_datai <= i_wr_data;
                  r_addr      <= w_addr_nxt;
                  r_rem       <= r_rem - 1'b1;
               end else if ((r_rem == '0) && r_mem_we) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // In-flight read tracking and the 2-entry output buffer (entry 0 is head).
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_inf      <= 1'b0;
         r_inf_last <= 1'b0;
         r_fdata    <= '0;
         r_flast    <= '0;
         r_cnt      <= 2'd0;
      end else begin
         r_inf      <= w_issue;
         r_inf_last <= w_issue && (r_rem == LWIDTH'(1));
         case ({r_inf, w_pop})
            2'b10: begin
               r_fdata[r_cnt[0]] <= i_mem_datao;
               r_flast[r_cnt[0]] <= r_inf_last;
               r_cnt             <= r_cnt + 1'b1;
            end
            2'b01: begin
               r_fdata[0] <= r_fdata[1];
               r_flast[0] <= r_flast[1];
               r_cnt      <= r_cnt - 1'b1;
            end
            2'b11: begin
               if (r_cnt == 2'd1) begin
                  r_fdata[0] <= i_mem_datao;
                  r_flast[0] <= r_inf_last;
               end else begin
                  r_fdata[0] <= r_fdata[1];
                  r_flast[0] <= r_flast[1];
                  r_fdata[1] <= i_mem_datao;
                  r_flast[1] <= r_inf_last;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_burst_master.sv
// Directed bench for bram_burst_master with a 16x8 registered-read BRAM model.
module tb_bram_burst_master;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [3:0] cmd_addr;
   logic [4:0] cmd_len;
   logic       mem_we;
   logic [3:0] mem_addr;
   logic [7:0] mem_datai, mem_datao;
   logic       rd_valid, rd_ready, rd_last;
   logic [7:0] rd_data;
   logic       wr_valid, wr_ready;
   logic [7:0] wr_data;
   logic       done;

   logic [7:0] mem [16];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // BRAM model: write-first not needed, read returns old contents next cycle.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_datai;
      mem_datao <= mem[mem_addr];
   end

   bram_burst_master #(.DWIDTH(8), .WORDS(16)) dut (
      .i_clock(clk), .i_reset(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
      .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
      .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_datai(mem_datai),
      .i_mem_datao(mem_datao),
      .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data),
      .o_rd_last(rd_last),
      .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
      .o_done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_mem_we"},    mem_we,    0);
      chk({tag, "_mem_addr"},  mem_addr,  0);
      chk({tag, "_mem_datai"}, mem_datai, 0);
      chk({tag, "_rd_valid"},  rd_valid,  0);
      chk({tag, "_rd_data"},   rd_data,   0);
      chk({tag, "_rd_last"},   rd_last,   0);
      chk({tag, "_wr_ready"},  wr_ready,  0);
      chk({tag, "_done"},      done,      0);
   endtask

   task automatic write_burst(input logic [3:0] a, input int n, input logic [7:0] base);
      cmd_valid = 1; cmd_write = 1; cmd_addr = a; cmd_len = 5'(n);
      wr_valid = 1; wr_data = base;
      step();
      cmd_valid = 0;
      for (int k = 0; k < n; k++) begin
         step();
         wr_data = base + 8'(k + 1);
      end
      wr_valid = 0;
      step();
      chk("wb_done", done, 1);
      step();
   endtask

   logic [7:0] bp_exp [6];
   logic [7:0] a4;
   logic [7:0] hold_d;
   logic       hold_l, stalled, seen_done;
   int         idx, outstanding, wcount, dptr;
   logic       wv  [5];
   logic       ewe [8];

   initial begin
      rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
      rd_ready = 0; wr_valid = 0; wr_data = 0;
      bp_exp[0] = 8'hA2; bp_exp[1] = 8'hA3; bp_exp[2] = 8'h52;
      bp_exp[3] = 8'h53; bp_exp[4] = 8'h54; bp_exp[5] = 8'h55;
      wv[0] = 1; wv[1] = 0; wv[2] = 0; wv[3] = 1; wv[4] = 1;
      ewe[0] = 0; ewe[1] = 1; ewe[2] = 0; ewe[3] = 0;
      ewe[4] = 1; ewe[5] = 1; ewe[6] = 0; ewe[7] = 0;

      // Reset values during and after reset
      repeat (2) @(posedge clk);
      #1;
      chk_idle_outputs("rst_in");
      rst = 0;
      step();
      chk_idle_outputs("rst_out");

      // Write with wrap-around: addr 14 len 4
      cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd14; cmd_len = 5'd4;
      wr_valid = 1; wr_data = 8'hA0;
      step();
      cmd_valid = 0;
      chk("wr_ready_on", wr_ready, 1);
      chk("wr_busy_cmd_ready", cmd_ready, 0);
      chk("wr_no_we_yet", mem_we, 0);
      for (int k = 0; k < 4; k++) begin
         step();
         a4 = 8'(14 + k);
         chk("wr_we", mem_we, 1);
         chk("wr_addr", mem_addr, {28'd0, a4[3:0]});
         chk("wr_datai", mem_datai, 8'hA0 + 8'(k));
         chk("wr_done_low", done, 0);
         wr_data = 8'hA1 + 8'(k);
      end
      wr_valid = 0;
      chk("wr_ready_off", wr_ready, 0);
      step();
      chk("wr_done", done, 1);
      chk("wr_done_we", mem_we, 0);
      chk("wr_done_cmd_ready", cmd_ready, 1);
      step();
      chk("wr_done_pulse", done, 0);
      chk("wr_mem14", mem[14], 8'hA0);
      chk("wr_mem15", mem[15], 8'hA1);
      chk("wr_mem0",  mem[0],  8'hA2);
      chk("wr_mem1",  mem[1],  8'hA3);

      // Read at full rate: addr 14 len 4
      cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd14; cmd_len = 5'd4; rd_ready = 1;
      step();
      cmd_valid = 0;
      chk("rd_lat0_valid", rd_valid, 0);
      chk("rd_first_addr", mem_addr, 14);
      step();
      chk("rd_lat1_valid", rd_valid, 0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("rd_valid", rd_valid, 1);
         chk("rd_data", rd_data, 8'hA0 + 8'(k));
         chk("rd_last", rd_last, (k == 3) ? 1 : 0);
         chk("rd_no_done", done, 0);
      end
      step();
      chk("rd_end_valid", rd_valid, 0);
      chk("rd_done", done, 1);
      chk("rd_done_cmd_ready", cmd_ready, 1);
      step();
      chk("rd_done_pulse", done, 0);

      // Preload words 2..5, then read addr 0 len 6 under backpressure
      write_burst(4'd2, 4, 8'h52);
      cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd0; cmd_len = 5'd6; rd_ready = 0;
      step();
      cmd_valid = 0;
      idx = 0; seen_done = 0; stalled = 0; hold_d = 0; hold_l = 0;
      for (int c = 0; c < 60 && !seen_done; c++) begin
         if (done) begin
            seen_done = 1;
         end else begin
            if (!cmd_ready) begin
               outstanding = int'(mem_addr) - idx;
               chk("bp_outstanding_le2", (outstanding <= 2) ? 1 : 0, 1);
            end
            if (stalled) begin
               chk("bp_hold_valid", rd_valid, 1);
               chk("bp_hold_data", rd_data, hold_d);
               chk("bp_hold_last", rd_last, hold_l);
            end
            if (c == 3) begin
               chk("bp_cap_addr", mem_addr, 2);
               chk("bp_cap_data", rd_data, 8'hA2);
            end
            rd_ready = (c >= 4) ? c[0] : 1'b0;
            if (rd_valid && rd_ready) begin
               chk("bp_data", rd_data, (idx < 6) ? bp_exp[idx] : 8'hxx);
               chk("bp_last", rd_last, (idx == 5) ? 1 : 0);
               idx++;
            end
            stalled = rd_valid && !rd_ready;
            hold_d = rd_data;
            hold_l = rd_last;
            step();
         end
      end
      chk("bp_count", idx, 6);
      chk("bp_done_seen", seen_done, 1);
      rd_ready = 0;
      step();

      // Zero-length read then write
      cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd3; cmd_len = 5'd0; rd_ready = 1;
      step();
      cmd_valid = 0;
      chk("z_rd_done", done, 1);
      chk("z_rd_cmd_ready", cmd_ready, 1);
      chk("z_rd_valid", rd_valid, 0);
      chk("z_rd_we", mem_we, 0);
      step();
      chk("z_rd_done_pulse", done, 0);
      chk("z_rd_valid2", rd_valid, 0);
      cmd_valid = 1; cmd_write = 1; cmd_len = 5'd0; wr_valid = 1; wr_data = 8'hEE;
      step();
      cmd_valid = 0;
      chk("z_wr_done", done, 1);
      chk("z_wr_ready", wr_ready, 0);
      chk("z_wr_we", mem_we, 0);
      step();
      wr_valid = 0;
      chk("z_wr_done_pulse", done, 0);
      chk("z_wr_we2", mem_we, 0);
      chk("z_wr_mem3", mem[3], 8'h53);

      // Reset after the 2nd read handshake of a len 8 read
      cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd14; cmd_len = 5'd8; rd_ready = 1;
      step();
      cmd_valid = 0;
      step();
      step();
      chk("rr_d0", rd_data, 8'hA0);
      step();
      chk("rr_d1", rd_data, 8'hA1);
      step();
      rst = 1;
      #1;
      chk_idle_outputs("rr_async");
      step();
      chk_idle_outputs("rr_held");
      rst = 0;
      cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd15; cmd_len = 5'd2;
      step();
      cmd_valid = 0;
      step();
      step();
      chk("rr2_v0", rd_valid, 1);
      chk("rr2_d0", rd_data, 8'hA1);
      chk("rr2_l0", rd_last, 0);
      step();
      chk("rr2_d1", rd_data, 8'hA2);
      chk("rr2_l1", rd_last, 1);
      step();
      chk("rr2_done", done, 1);
      chk("rr2_valid_off", rd_valid, 0);
      step();

      // Busy command held through a gappy len 3 write
      cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd4; cmd_len = 5'd3; wr_valid = 0;
      step();
      cmd_write = 0; cmd_len = 5'd0;
      wcount = 0; dptr = 0;
      for (int s = 0; s < 8; s++) begin
         chk("bg_we", mem_we, ewe[s]);
         if (mem_we) wcount++;
         chk("bg_cmd_ready", cmd_ready, (s >= 6) ? 1 : 0);
         chk("bg_done", done, (s >= 6) ? 1 : 0);
         if (s < 5) begin
            wr_valid = wv[s];
            wr_data = 8'hC0 + 8'(dptr);
            if (wv[s]) dptr++;
         end else begin
            wr_valid = 0;
         end
         if (s == 7) cmd_valid = 0;
         step();
      end
      chk("bg_done_end", done, 0);
      chk("bg_write_count", wcount, 3);
      chk("bg_mem4", mem[4], 8'hC0);
      chk("bg_mem5", mem[5], 8'hC1);
      chk("bg_mem6", mem[6], 8'hC2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bram_burst_master.md
# bram_burst_master

Burst initiator that drives one port of a single-port block RAM with registered (1-cycle) read latency. It accepts a command of start address, length and direction. A read burst is streamed out on a valid/ready interface; a write burst is accepted from a valid/ready stream and committed to memory. The block sits between stream-based datapath blocks and the team's BRAM instances, and handles read latency and backpressure internally.

## Interface
Parameters:
- DWIDTH, 8, data word width
- WORDS, 4096, memory depth in words
- ADDRS, $clog2(WORDS), address width
- LWIDTH, ADDRS+1, burst length width (lengths 0..WORDS)

Ports:
- CLOCK  in  1  main clock, all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  command accepted when both high; high only in IDLE
- CMD_WRITE  in  1  1 = write burst, 0 = read burst
- CMD_ADDR  in  ADDRS  start word address
- CMD_LEN  in  LWIDTH  number of words; 0 = no-op
- MEM_WE  out  1  BRAM write enable
- MEM_ADDR  out  ADDRS  BRAM address
- MEM_DATAI  out  DWIDTH  BRAM write data
- MEM_DATAO  in  DWIDTH  BRAM read data, valid one cycle after its address is sampled
- RD_VALID  out  1  read data available
- RD_READY  in  1  downstream accepts read data
- RD_DATA  out  DWIDTH  read data
- RD_LAST  out  1  marks the final word of a read burst
- WR_VALID  in  1  write data offered
- WR_READY  out  1  write data accepted when both high
- WR_DATA  in  DWIDTH  write data
- DONE  out  1  one-cycle pulse when the burst completes

## Operation
- States: IDLE, READ, WRITE. The DONE pulse coincides with the return to IDLE.
- IDLE:
  - CMD_READY=1.
  - On a handshake, latch the address and length, then go to READ or WRITE.
  - If CMD_LEN=0, stay in IDLE and pulse DONE on the next cycle. There is no memory or stream activity.
- Address counter:
  - Increments by 1 per issued word.
  - Wraps from WORDS-1 to 0, including when WORDS is not a power of two.
- Remaining-length counter: decrements per issued word.
- READ:
  - The output buffer is a 2-entry FIFO.
  - An address is issued (MEM_ADDR updated, MEM_WE=0) only if FIFO occupancy plus in-flight reads is less than 2 and words remain to issue.
  - MEM_DATAO is pushed into the FIFO one cycle after issue.
  - RD_VALID = FIFO not empty; RD_DATA = FIFO head.
  - RD_LAST=1 with the final word only.
  - The block leaves READ after the RD_LAST handshake.
- WRITE:
  - WR_READY=1 while words remain.
  - Each WR handshake registers MEM_WE=1, MEM_ADDR=current address and MEM_DATAI=WR_DATA for the next cycle. MEM_WE=0 otherwise.
  - The block leaves WRITE in the cycle after the last MEM_WE=1 cycle.
- CMD_VALID during a busy period is ignored; the command is held until IDLE.
- Holding rules:
  - RD_DATA and RD_LAST stay stable while RD_VALID=1 and RD_READY=0.
  - WR_VALID gaps insert idle cycles with no write.
- Reset values (also the values during reset):
  - state IDLE, CMD_READY=1.
  - MEM_WE=0, MEM_ADDR=0, MEM_DATAI=0.
  - RD_VALID=0, RD_DATA=0, RD_LAST=0.
  - WR_READY=0, DONE=0.
  - FIFO and in-flight count cleared.
- Reset mid-burst: the burst is aborted immediately and a pending MEM_WE is dropped. Memory already written is not restored.

## Timing
- Read latency: a command handshake at edge e0 gives the first MEM_ADDR at e1 (sampled by the BRAM) and RD_VALID=1 after e2.
- Read throughput: 1 word/cycle with RD_READY held at 1. There are no bubbles after the first word.
- Read backpressure: with RD_READY=0, at most 2 words are buffered and issue stalls. Issue resumes the cycle after a pop.
- Write: a WR handshake at edge e gives MEM_WE=1 in cycle e..e+1, and the BRAM commits at e+1. Throughput is 1 word/cycle.
- DONE:
  - Read: high in the cycle after the RD_LAST handshake.
  - Write: high in the cycle after the last MEM_WE=1 cycle.
  - In both cases CMD_READY=1 in the same cycle, so back-to-back commands are allowed.

## Test plan
All scenarios use DWIDTH=8, WORDS=16.
- Write, wrap-around: CMD write addr 14 len 4, data A0..A3 with WR_VALID held → 4 consecutive MEM_WE cycles; memory[14,15,0,1]=A0,A1,A2,A3; DONE pulses once.
- Read, full rate: CMD read addr 14 len 4 with RD_READY=1 → RD_DATA A0..A3 on 4 consecutive cycles starting 2 cycles after the handshake; RD_LAST on A3 only; DONE on the next cycle.
- Read with backpressure: read addr 0 len 6, RD_READY toggled 1,0,1,0 → six words in order with none lost or duplicated; RD_DATA stable while stalled; never more than 2 reads outstanding.
- Zero length: CMD len 0 (read and write) → DONE one cycle later; MEM_WE, RD_VALID and WR_READY stay 0.
- Reset mid-read: assert RESET after the 2nd RD handshake of a len 8 read → all outputs at reset values immediately; after release, a len 2 read returns correct data.
- Busy and gappy: CMD_VALID held through a len 3 write with WR_VALID pattern 1,0,0,1,1 → second command accepted only in the DONE cycle; exactly 3 writes, no write on gap cycles.
